uart_rx: RTL

//  Serial receiver, 8N1, LSB first, idle-high line. Consumes the line driven by
//  the uart_tx serializer (loopback on the board, or external host link).

---
 rtl/uart_pkg.sv | 16 +
 rtl/uart_sync2.sv | 22 ++
 rtl/uart_rx.sv | 109 ++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: bit period default, data width and receiver state encoding.
// Both uart_tx and uart_rx import this so the two ends agree on the bit period.
package uart_pkg;

  localparam int BAUD_DIV_DEFAULT = 2604;
  localparam int DATA_BITS        = 8;

  localparam logic [0:0] ST_IDLE    = 1'b0;
  localparam logic [0:0] ST_RECEIVE = 1'b1;

  typedef enum logic [0:0] {
    IDLE    = ST_IDLE,
    RECEIVE = ST_RECEIVE
  } rx_state_t;

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for the asynchronous serial line.
// Resets to 1 so an idle-high line never produces a spurious start bit.
module uart_sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// 8N1 serial receiver: start-bit detect, mid-bit sampling, sticky rdy/ovr flags.
// A stop bit sampled low holds the receiver in IDLE until the line returns high.
module uart_rx
  import uart_pkg::*;
#(
  parameter int BAUD_DIV = BAUD_DIV_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx,
  input  logic                 clr_rdy,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rdy,
  output logic                 frm_err,
  output logic                 ovr
);

  localparam int              BW        = $clog2(BAUD_DIV);
  localparam logic [BW-1:0]   HALF_LOAD = BW'(BAUD_DIV / 2 - 1);
  localparam logic [BW-1:0]   FULL_LOAD = BW'(BAUD_DIV - 1);
  localparam logic [3:0]      STOP_IDX  = 4'(DATA_BITS + 1);

  logic                 rx_s;
  rx_state_t            state;
  rx_state_t            state_next;
  logic [BW-1:0]        baud;
  logic [3:0]           bit_cnt;
  logic [DATA_BITS-1:0] shreg;
  logic                 brk_wait;
  logic                 arm;
  logic                 sample;
  logic                 done;

  uart_sync2 u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (rx),
    .q     (rx_s)
  );

  assign arm    = (state == IDLE) && !brk_wait && !rx_s;
  assign sample = (state == RECEIVE) && (baud == '0);
  assign done   = sample && (bit_cnt == STOP_IDX);

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (arm) state_next = RECEIVE;
      RECEIVE: if (sample && ((bit_cnt == 4'd0 && rx_s) || bit_cnt == STOP_IDX))
                 state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // The start bit is shifted in too; it falls off the bottom after the 8th data bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      baud    <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
    end else if (arm) begin
      baud    <= HALF_LOAD;
      bit_cnt <= '0;
    end else if (state == RECEIVE) begin
      if (sample) begin
        shreg   <= {rx_s, shreg[DATA_BITS-1:1]};
        baud    <= FULL_LOAD;
        bit_cnt <= done ? bit_cnt : bit_cnt + 4'd1;
      end else begin
        baud <= baud - BW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      brk_wait <= 1'b0;
    end else if (done) begin
      brk_wait <= ~rx_s;
    end else if (state == IDLE && rx_s) begin
      brk_wait <= 1'b0;
    end
  end

  // Frame completion takes priority over a simultaneous consumer ack.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_data <= '0;
      rdy     <= 1'b0;
      frm_err <= 1'b0;
      ovr     <= 1'b0;
    end else if (done) begin
      rx_data <= shreg;
      rdy     <= 1'b1;
      frm_err <= ~rx_s;
      ovr     <= ovr | rdy;
    end else if (clr_rdy) begin
      rdy     <= 1'b0;
      frm_err <= 1'b0;
      ovr     <= 1'b0;
    end
  end

endmodule
